// File: rtl/snake_pkg.sv
// Shared constants, the BCD digit type and the glyph renderer for the snake score overlay.
package snake_pkg;
  localparam int GLYPH_W       = 10;
  localparam int GLYPH_H       = 16;
  localparam int GLYPH_PIXELS  = GLYPH_W * GLYPH_H;
  localparam int BCD_MAX_DIGIT = 9;

  typedef logic [3:0] bcd_digit_t;

  // Lit segments of each numeral, packed as {g,f,e,d,c,b,a}.
  function automatic logic [6:0] digit_segments(input int d);
    case (d)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Bars are h/8 rows thick, side columns w/5 wide; the middle bar straddles h/2.
  function automatic logic glyph_pixel(input int d, input int row, input int col,
                                       input int w, input int h);
    logic [6:0] s;
    int         t;
    int         sw;
    int         mid;
    logic       hbar;
    logic       lcol;
    logic       rcol;
    s    = digit_segments(d);
    t    = h / 8;
    sw   = w / 5;
    mid  = h / 2;
    hbar = (col >= sw) && (col < w - sw);
    lcol = (col < sw);
    rcol = (col >= w - sw);
    return (s[0] && row < t && hbar) ||
           (s[1] && row >= t && row < mid && rcol) ||
           (s[2] && row >= mid && row < h - t && rcol) ||
           (s[3] && row >= h - t && hbar) ||
           (s[4] && row >= mid && row < h - t && lcol) ||
           (s[5] && row >= t && row < mid && lcol) ||
           (s[6] && row >= mid - 1 && row <= mid && hbar);
  endfunction
endpackage

// File: rtl/digit_font_rom.sv
// Ten-glyph font ROM with a registered pixel output; out-of-range digit or address reads 0.
module digit_font_rom #(
  parameter int GLYPH_W = snake_pkg::GLYPH_W,
  parameter int GLYPH_H = snake_pkg::GLYPH_H,
  parameter int ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  snake_pkg::bcd_digit_t digit,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  pixel
);
  import snake_pkg::*;

  localparam int PIX   = GLYPH_W * GLYPH_H;
  localparam int IDX_W = $clog2(10 * PIX + (1 << ADDR_W));

  function automatic logic [10*PIX-1:0] build_font();
    logic [10*PIX-1:0] f;
    f = '0;
    for (int d = 0; d < 10; d++)
      for (int r = 0; r < GLYPH_H; r++)
        for (int c = 0; c < GLYPH_W; c++)
          f[d*PIX + r*GLYPH_W + c] = glyph_pixel(d, r, c, GLYPH_W, GLYPH_H);
    return f;
  endfunction

  localparam logic [10*PIX-1:0] FONT = build_font();

  logic [IDX_W-1:0] idx;
  logic             pixel_d;
  logic             pixel_q;

  always_comb begin
    idx     = IDX_W'(digit) * IDX_W'(PIX) + IDX_W'(addr);
    pixel_d = 1'b0;
    if (digit <= bcd_digit_t'(BCD_MAX_DIGIT) && {1'b0, addr} < (ADDR_W+1)'(PIX))
      pixel_d = FONT[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel_q <= 1'b0;
    else        pixel_q <= pixel_d;
  end

  assign pixel = pixel_q;
endmodule

// File: rtl/score_digit_server.sv
// Live BCD score, per-frame shadow copy and one-cycle glyph query path.
// Define SCORE_SATURATE_EN to hold the score at 99 instead of wrapping to 00.
module score_digit_server #(
  parameter int GLYPH_W = snake_pkg::GLYPH_W,
  parameter int GLYPH_H = snake_pkg::GLYPH_H,
  parameter int ADDR_W  = 8
) (
  input  logic                  clock_25,
  input  logic                  reset,
  input  logic                  fruit_eaten,
  input  logic                  score_clear,
  input  logic                  frame_start,
  input  logic                  digit_sel,
  input  logic [ADDR_W-1:0]     number_count,
  output logic                  number_pixel,
  output snake_pkg::bcd_digit_t selected_number,
  output snake_pkg::bcd_digit_t score_tens,
  output snake_pkg::bcd_digit_t score_units,
  output logic                  score_wrap
);
  import snake_pkg::*;

  localparam bcd_digit_t BCD_MAX = bcd_digit_t'(BCD_MAX_DIGIT);

  bcd_digit_t units_q, units_d;
  bcd_digit_t tens_q, tens_d;
  bcd_digit_t sh_units_q, sh_tens_q;
  bcd_digit_t sel_q;
  bcd_digit_t query_digit;

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (score_clear) begin
      units_d = '0;
      tens_d  = '0;
    end else if (fruit_eaten) begin
      if (units_q != BCD_MAX) begin
        units_d = units_q + 4'd1;
      end else if (tens_q != BCD_MAX) begin
        units_d = '0;
        tens_d  = tens_q + 4'd1;
      end else begin
`ifdef SCORE_SATURATE_EN
        units_d = units_q;
        tens_d  = tens_q;
`else
        units_d = '0;
        tens_d  = '0;
`endif
      end
    end
  end

  // Shadow samples the pre-update live score, so a coincident event lands next frame.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      units_q    <= '0;
      tens_q     <= '0;
      sh_units_q <= '0;
      sh_tens_q  <= '0;
      sel_q      <= '0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      if (frame_start) begin
        sh_units_q <= units_q;
        sh_tens_q  <= tens_q;
      end
      sel_q <= query_digit;
    end
  end

`ifdef SCORE_SATURATE_EN
  assign score_wrap = 1'b0;
`else
  logic wrap_d;
  logic wrap_q;

  assign wrap_d = fruit_eaten && !score_clear && (units_q == BCD_MAX) && (tens_q == BCD_MAX);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign score_wrap = wrap_q;
`endif

  assign query_digit = digit_sel ? sh_tens_q : sh_units_q;

  digit_font_rom #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .ADDR_W  (ADDR_W)
  ) u_font (
    .clk   (clock_25),
    .rst_n (reset),
    .digit (query_digit),
    .addr  (number_count),
    .pixel (number_pixel)
  );

  assign selected_number = sel_q;
  assign score_tens      = tens_q;
  assign score_units     = units_q;
endmodule

// File: doc/score_digit_server.md
# score_digit_server

Responder side of the score-overlay pixel interface. It keeps the live two-digit BCD score from fruit-eaten events. Once per frame it latches a stable display copy. It answers per-pixel glyph queries (digit select plus glyph address) with the pixel bit one cycle later. It sits between the game FSM, which produces events, and the score display controller, which issues the queries. Its output feeds the VGA colour mux.

## Interface
Parameters:
- GLYPH_W, 10: glyph width in pixels.
- GLYPH_H, 16: glyph height in pixels.
- ADDR_W, 8: width of glyph address; must satisfy 2^ADDR_W ≥ GLYPH_W*GLYPH_H.

Ports:
- clock_25  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- fruit_eaten  in  1  one-cycle pulse; score +1.
- score_clear  in  1  one-cycle pulse; new game, score to 00.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- digit_sel  in  1  query digit: 0 = units, 1 = tens.
- number_count  in  ADDR_W  glyph address, col + GLYPH_W*row, 0..159.
- number_pixel  out  1  glyph bit for the queried digit and address.
- selected_number  out  4  displayed BCD value of the queried digit.
- score_tens  out  4  live tens digit, BCD.
- score_units  out  4  live units digit, BCD.
- score_wrap  out  1  one-cycle pulse when the live score passes 99.

## Operation
- Live score is two BCD nibbles, units and tens, each 0..9.
- Increment on fruit_eaten:
  - units 9 → 0 with carry into tens.
  - tens 9 with carry → see Configuration.
- score_clear has priority over fruit_eaten in the same cycle; the result is 00 and no increment.
- Shadow (display) score:
  - Loaded from the live score on frame_start.
  - Queries read only the shadow, so no digit changes mid-frame.
  - If frame_start and fruit_eaten coincide, the shadow takes the pre-increment value.
  - If frame_start and score_clear coincide, the shadow takes the pre-clear value.
- Query path:
  - digit_sel selects the shadow nibble.
  - Nibble and number_count address the font ROM: 10 glyphs × GLYPH_W*GLYPH_H bits.
  - number_count ≥ GLYPH_W*GLYPH_H gives number_pixel = 0.
  - A nibble > 9 (impossible in legal operation) gives number_pixel = 0.
- selected_number is the registered shadow nibble chosen by digit_sel.

## Timing
- Reset (asynchronous, on reset low): all of the following are 0:
  - live and shadow scores
  - number_pixel, selected_number, score_tens, score_units, score_wrap
- Live score visible on score_tens and score_units 1 cycle after the fruit_eaten or score_clear edge.
- Shadow updated at the frame_start edge; queries see the new value from the next cycle.
- Query latency is exactly 1 cycle. For digit_sel and number_count sampled at edge N:
  - number_pixel and selected_number are valid after edge N, until edge N+1.
  - Fully pipelined: one new query per cycle, no stalls, no handshake.
- score_wrap is high for the single cycle following the 99 → next increment.
- Reset asserted mid-frame clears the shadow. The display shows 00 until reset is released, then 00 until the next frame_start.

## Configuration
- SCORE_SATURATE_EN defined:
  - At 99, fruit_eaten leaves the score at 99.
  - score_wrap never pulses; the port is tied 0.
- SCORE_SATURATE_EN not defined:
  - 99 + 1 wraps to 00.
  - score_wrap pulses.

## Structure
- Shared package snake_pkg holds:
  - GLYPH_W, GLYPH_H, GLYPH_PIXELS (=160), BCD_MAX_DIGIT (=9).
  - A bcd_digit_t 4-bit typedef, shared with the score display controller.
- Sub-module digit_font_rom:
  - Inputs: digit (4 bit) and address (ADDR_W).
  - Registered 1-bit output.
  - Holds the ten 10×16 bitmaps as a constant array.
  - Out-of-range digit or address → 0.
- BCD counter and shadow latch live in the top module.

## Test plan
- Reset low mid-operation with score 37 → score_tens = 0, score_units = 0, number_pixel = 0 immediately. After release and frame_start, querying digit_sel = 1 returns selected_number = 0.
- 12 fruit_eaten pulses from 00 → live 12. Shadow stays 00 until frame_start, then selected_number = 1 for digit_sel = 1 and 2 for digit_sel = 0.
- Score 09 plus fruit_eaten → live 10; units carry verified.
- Score 99 plus fruit_eaten:
  - Macro defined → 99, no score_wrap.
  - Macro not defined → 00 and score_wrap high for 1 cycle.
- fruit_eaten, score_clear and frame_start all in the same cycle at score 45 → live 00, shadow 45.
- Sweep number_count 0..159 then 160..255 for digit 8 → number_pixel matches the golden bitmap with 1-cycle delay; 0 for every address ≥160.
